// File: rtl/univ_shift_register.sv
// univ_shift_register: parametrised register with enable, load, variable shifts/rotates, clear, carry-out and zero flag
module univ_shift_register #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         mode,
  input  logic [WIDTH-1:0]   d,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               sin,
  output logic [WIDTH-1:0]   q,
  output logic               cout,
  output logic               zero
);
  localparam int KW = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);
  typedef enum logic [2:0] {HOLD, LOAD, SHL, SHR, ROTL, ROTR, ASR, CLR} mode_t;
  logic [KW-1:0]    k, kk, kr;
  logic             fill;
  logic [WIDTH-1:0] nq;
  logic             ncout;
  // Shifts run on q padded with the fill bits plus one guard bit that catches the last bit out.
  always_comb begin
    k     = KW'(shamt);
    kk    = (k >= KW'(WIDTH)) ? KW'(WIDTH) : k;
    kr    = k % KW'(WIDTH);
    fill  = (mode_t'(mode) == ASR) ? q[WIDTH-1] : sin;
    nq    = q;
    ncout = cout;
    case (mode_t'(mode))
      LOAD: nq = d;
      SHL: if (kk != '0) begin
        nq    = WIDTH'(({1'b0, q, {WIDTH{sin}}} << kk) >> WIDTH);
        ncout = 1'(({1'b0, q, {WIDTH{sin}}} << kk) >> (2 * WIDTH));
      end
      SHR, ASR: if (kk != '0) begin
        nq    = WIDTH'(({{WIDTH{fill}}, q, 1'b0} >> kk) >> 1);
        ncout = 1'({{WIDTH{fill}}, q, 1'b0} >> kk);
      end
      ROTL: if (kr != '0) begin
        nq    = WIDTH'(({q, q} << kr) >> WIDTH);
        ncout = nq[0];
      end
      ROTR: if (kr != '0) begin
        nq    = WIDTH'({q, q} >> kr);
        ncout = nq[WIDTH-1];
      end
      CLR: begin
        nq    = '0;
        ncout = 1'b0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      cout <= 1'b0;
    end else if (en) begin
      q    <= nq;
      cout <= ncout;
    end
  end
  assign zero = ~|q;
endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: scoreboard bench for univ_shift_register at WIDTH=8, SHAMT_W=4
module tb_univ_shift_register;
  localparam int W  = 8;
  localparam int SW = 4;
  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                         ROTL = 3'd4, ROTR = 3'd5, ASR = 3'd6, CLR = 3'd7;
  logic          clk = 1'b0;
  logic          rst, en, sin, cout, zero;
  logic [2:0]    mode;
  logic [W-1:0]  d, q;
  logic [SW-1:0] shamt;
  int passed = 0;
  int total  = 0;
  logic [W+1:0] sb[$];
  logic [W+1:0] exp_v;
  logic [W-1:0] mq;
  logic         mc;
  typedef struct packed {
    logic         e;
    logic [2:0]   m;
    logic [W-1:0] d;
    logic [SW-1:0] k;
    logic         s;
    logic [W-1:0] eq;
    logic         ec;
  } step_t;

  univ_shift_register #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .shamt(shamt),
    .sin(sin), .q(q), .cout(cout), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic drive(input step_t st);
    @(negedge clk);
    en    = st.e;
    mode  = st.m;
    d     = st.d;
    shamt = st.k;
    sin   = st.s;
    sb.push_back({st.eq, st.ec, st.eq == '0});
  endtask

  task automatic test_reset;
    step_t st [2] = '{'{1'b1, LOAD, 8'hFF, 4'd0, 1'b0, 8'hFF, 1'b0},
                      '{1'b1, ROTL, 8'h00, 4'd1, 1'b0, 8'hFF, 1'b1}};
    step_t ld = '{1'b1, LOAD, 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0};
    rst = 1'b1; en = 1'b0; mode = HOLD; d = '0; shamt = '0; sin = 1'b0;
    #12;
    sb.push_back({8'h00, 1'b0, 1'b1});
    exp_v = sb.pop_front();
    total++;
    if ({q, cout, zero} !== exp_v) $display("FAIL reset_init: q/cout/zero got %h/%b/%b expected %h/%b/%b", q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL reset_setup step %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    sb.push_back({8'h00, 1'b0, 1'b1});
    #1;
    exp_v = sb.pop_front();
    total++;
    if ({q, cout, zero} !== exp_v) $display("FAIL reset_async: q/cout/zero got %h/%b/%b expected %h/%b/%b", q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
    else passed++;
    #1 rst = 1'b0;
    drive(ld);
    @(posedge clk); #1;
    exp_v = sb.pop_front();
    total++;
    if ({q, cout, zero} !== exp_v) $display("FAIL reset_release_load: q/cout/zero got %h/%b/%b expected %h/%b/%b", q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
    else passed++;
  endtask

  task automatic test_shl_enable;
    step_t st [3] = '{'{1'b1, SHL, 8'h00, 4'd1, 1'b1, 8'h4B, 1'b1},
                      '{1'b0, SHL, 8'h00, 4'd3, 1'b1, 8'h4B, 1'b1},
                      '{1'b0, SHL, 8'h00, 4'd3, 1'b0, 8'h4B, 1'b1}};
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL shl_enable step %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  task automatic test_rotate;
    step_t st [4] = '{'{1'b1, LOAD, 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b1},
                      '{1'b1, ROTR, 8'h00, 4'd3, 1'b0, 8'hB4, 1'b1},
                      '{1'b1, ROTL, 8'h00, 4'd8, 1'b0, 8'hB4, 1'b1},
                      '{1'b1, ROTL, 8'h00, 4'd0, 1'b1, 8'hB4, 1'b1}};
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL rotate step %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  task automatic test_asr_shr;
    step_t st [5] = '{'{1'b1, LOAD, 8'h84, 4'd0, 1'b0, 8'h84, 1'b1},
                      '{1'b1, ASR,  8'h00, 4'd2, 1'b0, 8'hE1, 1'b0},
                      '{1'b1, ASR,  8'h00, 4'd15, 1'b0, 8'hFF, 1'b1},
                      '{1'b1, SHR,  8'h00, 4'd12, 1'b0, 8'h00, 1'b1},
                      '{1'b1, SHL,  8'h00, 4'd8, 1'b1, 8'hFF, 1'b0}};
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL asr_shr step %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  task automatic test_clr_hold;
    step_t st [6] = '{'{1'b1, LOAD, 8'h3C, 4'd0, 1'b0, 8'h3C, 1'b0},
                      '{1'b1, SHL,  8'h00, 4'd0, 1'b1, 8'h3C, 1'b0},
                      '{1'b1, CLR,  8'h00, 4'd0, 1'b0, 8'h00, 1'b0},
                      '{1'b1, HOLD, 8'h55, 4'd0, 1'b1, 8'h00, 1'b0},
                      '{1'b1, HOLD, 8'hAA, 4'd3, 1'b0, 8'h00, 1'b0},
                      '{1'b1, HOLD, 8'h55, 4'd7, 1'b1, 8'h00, 1'b0}};
    foreach (st[i]) begin
      drive(st[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL clr_hold step %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  // Reference: one bit moved per iteration, so multi-bit shifts are repeated single steps.
  task automatic model(input logic e, input logic [2:0] m, input logic [W-1:0] dd, input int k, input logic s);
    int kk = (k > W) ? W : k;
    int kr = k % W;
    if (!e) return;
    case (m)
      LOAD: mq = dd;
      SHL:  for (int j = 0; j < kk; j++) begin mc = mq[W-1]; mq = {mq[W-2:0], s}; end
      SHR:  for (int j = 0; j < kk; j++) begin mc = mq[0]; mq = {s, mq[W-1:1]}; end
      ASR:  for (int j = 0; j < kk; j++) begin mc = mq[0]; mq = {mq[W-1], mq[W-1:1]}; end
      ROTL: if (kr > 0) begin for (int j = 0; j < kr; j++) mq = {mq[W-2:0], mq[W-1]}; mc = mq[0]; end
      ROTR: if (kr > 0) begin for (int j = 0; j < kr; j++) mq = {mq[0], mq[W-1:1]}; mc = mq[W-1]; end
      CLR:  begin mq = '0; mc = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic test_random;
    step_t st;
    mq = 8'h00;
    mc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      st.e = ($urandom_range(9) != 0);
      st.m = 3'($urandom_range(7));
      if ($urandom_range(5) == 0) st.m = LOAD;
      st.d = 8'($urandom);
      st.k = 4'($urandom);
      st.s = 1'($urandom);
      model(st.e, st.m, st.d, int'(st.k), st.s);
      st.eq = mq;
      st.ec = mc;
      drive(st);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      total++;
      if ({q, cout, zero} !== exp_v) $display("FAIL random step %0d mode %0d k %0d: q/cout/zero got %h/%b/%b expected %h/%b/%b", i, st.m, st.k, q, cout, zero, exp_v[W+1:2], exp_v[1], exp_v[0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_shl_enable;
    test_rotate;
    test_asr_shr;
    test_clr_hold;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
